sdc_wb_arbiter: RTL and testbench
=================================

SDC_WB_ARBITER -- requirements
Module: sdc_wb_arbiter

Interface
REQ-001 The block SHALL take parameter AW, default 30, meaning the word-address width.
REQ-002 The block SHALL take parameter DW, default 32, meaning the data width.
REQ-003 The block SHALL take parameter TIMEOUT, default 1024, meaning the maximum number of cycles a strobe may wait for ack or err, legal range 2..65535.
REQ-004 The block SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-005 aclk  in  1  sole clock; all state updates on the rising edge.
REQ-006 areset  in  1  asynchronous, active-high reset.
REQ-007 i_sN_cyc, i_sN_stb, i_sN_we  in  1 each  Wishbone classic requester N, N=0 (SD DMA) or N=1 (boot/debug sequencer).
REQ-008 i_sN_addr  in  AW  requester N word address.
REQ-009 i_sN_data  in  DW  requester N write data.
REQ-010 i_sN_sel  in  DW/8  requester N byte select.
REQ-011 o_sN_ack, o_sN_err  out  1 each  termination signals routed to requester N.
REQ-012 o_s_data  out  DW  read data, shared by both requesters.
REQ-013 o_mcyc, o_mstb, o_mwe, o_maddr[AW], o_mdata[DW], o_msel[DW/8]  out  downstream Wishbone classic master.
REQ-014 i_mack, i_merr  in  1 each  downstream termination.
REQ-015 i_mdata  in  DW  downstream read data.
REQ-016 o_grant  out  2  one-hot current owner; 00 when no requester owns the bus.
REQ-017 o_timeout  out  1  one-cycle pulse when the watchdog fires.

Function
REQ-018 The FSM SHALL have three states: IDLE, BUSY and ABORT.
REQ-019 In IDLE, when at least one i_sN_cyc is high, the FSM SHALL latch a grant and enter BUSY on the next edge; arbitration latency is 1 cycle.
REQ-020 Grant selection SHALL be round-robin: when both requesters ask, grant goes to the requester not granted last; a single requester is always granted.
REQ-021 In BUSY, the o_m* outputs SHALL combinationally mirror the granted requester's inputs.
REQ-022 In BUSY, i_mack and i_merr SHALL be routed only to the granted requester; the non-granted requester's ack and err SHALL be 0.
REQ-023 o_s_data SHALL equal i_mdata at all times.
REQ-024 In BUSY, when the granted requester's cyc goes low, the FSM SHALL enter IDLE; o_mcyc SHALL be low for at least 1 cycle between two grants.
REQ-025 The grant SHALL be held for the whole cyc, including multiple strobes; the other requester waits with no ack or err.
REQ-026 The watchdog counter SHALL clear on entry to BUSY and on every i_mack or i_merr.
REQ-027 The watchdog counter SHALL count cycles in BUSY with stb high and no termination.
REQ-028 When the watchdog count reaches TIMEOUT-1 with no termination in that cycle, the block SHALL assert o_sN_err to the owner and o_timeout for exactly 1 cycle, force o_mcyc/o_mstb to 0, and enter ABORT.
REQ-029 If i_mack or i_merr arrives in the same cycle the watchdog count reaches TIMEOUT-1, the termination SHALL win and no timeout is raised.
REQ-030 In ABORT, all o_m* control outputs and both acks/errs SHALL be 0, o_grant SHALL be held, and the FSM SHALL return to IDLE once the owner drops cyc.
REQ-031 Any i_mack or i_merr arriving in IDLE or ABORT SHALL be discarded.

Reset
REQ-032 While areset is high, o_mcyc, o_mstb, o_mwe, all acks/errs, o_grant and o_timeout SHALL be 0, the FSM SHALL be in IDLE and the watchdog counter SHALL be 0.
REQ-033 The round-robin pointer SHALL reset to "last = requester 1", so that requester 0 wins the first contention.
REQ-034 Reset asserted mid-transfer SHALL drop o_mcyc in the same cycle, without waiting for a clock edge.

Structure
REQ-035 Package sdc_pkg SHALL hold the FSM state enum, the default AW/DW constants and the watchdog counter width (16).
REQ-036 The watchdog SHALL be a separate sub-module, sdc_wb_watchdog (inputs clear and count enable, output expired).
REQ-037 Arbitration and muxing SHALL reside in the top module.

Verification
REQ-038 Reset release, then i_s0_cyc/stb with a read of addr 0x10 and i_mack after 3 cycles -> o_grant=01 one cycle after the request, o_s0_ack for 1 cycle, o_s1_ack=0.
REQ-039 Both requesters raise cyc in the same cycle after reset -> s0 is granted first; after s0 drops cyc, one idle cycle, then o_grant=10.
REQ-040 With TIMEOUT=8, a request is held with no downstream ack -> o_timeout and o_s0_err both pulse on cycle 8 of BUSY, o_mcyc=0 in that cycle, and the FSM returns to IDLE after s0 drops cyc.
REQ-041 With TIMEOUT=8, i_mack arrives exactly on the cycle the watchdog count reaches 7 -> ack is delivered and o_timeout stays 0.
REQ-042 areset is pulsed mid-burst while s1 owns the bus -> all outputs read 0 before the next edge, and s0 wins the next contention.

Source files
------------

// File: rtl/sdc_pkg.sv
// Shared types and constants for the SD-controller Wishbone arbiter slice.
package sdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } sdc_state_t;

  localparam int SDC_AW   = 30;
  localparam int SDC_DW   = 32;
  localparam int SDC_WD_W = 16;

endpackage

// File: rtl/sdc_wb_watchdog.sv
// Bus watchdog: counts stalled strobe cycles and flags the cycle that reaches TIMEOUT-1.
module sdc_wb_watchdog
  import sdc_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic cnt_en,
  output logic expired
);

  localparam logic [SDC_WD_W-1:0] LIMIT = SDC_WD_W'(TIMEOUT - 1);

  logic [SDC_WD_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (cnt_en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // cnt_en already excludes a termination, so an ack on the limit cycle wins.
  assign expired = cnt_en && (cnt_q == LIMIT);

endmodule

// File: rtl/sdc_wb_arbiter.sv
// Two-requester round-robin Wishbone classic arbiter with a stalled-bus watchdog.
module sdc_wb_arbiter
  import sdc_pkg::*;
#(
  parameter int AW      = SDC_AW,
  parameter int DW      = SDC_DW,
  parameter int TIMEOUT = 1024
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic            i_s0_cyc,
  input  logic            i_s0_stb,
  input  logic            i_s0_we,
  input  logic [AW-1:0]   i_s0_addr,
  input  logic [DW-1:0]   i_s0_data,
  input  logic [DW/8-1:0] i_s0_sel,
  output logic            o_s0_ack,
  output logic            o_s0_err,
  input  logic            i_s1_cyc,
  input  logic            i_s1_stb,
  input  logic            i_s1_we,
  input  logic [AW-1:0]   i_s1_addr,
  input  logic [DW-1:0]   i_s1_data,
  input  logic [DW/8-1:0] i_s1_sel,
  output logic            o_s1_ack,
  output logic            o_s1_err,
  output logic [DW-1:0]   o_s_data,
  output logic            o_mcyc,
  output logic            o_mstb,
  output logic            o_mwe,
  output logic [AW-1:0]   o_maddr,
  output logic [DW-1:0]   o_mdata,
  output logic [DW/8-1:0] o_msel,
  input  logic            i_mack,
  input  logic            i_merr,
  input  logic [DW-1:0]   i_mdata,
  output logic [1:0]      o_grant,
  output logic            o_timeout
);

  sdc_state_t state_q;
  logic [1:0] grant_q;
  logic       last_q;
  logic       own1, own_cyc, own_stb, own_we, busy, term;
  logic       wd_clear, wd_en, expired;

  assign own1    = grant_q[1];
  assign own_cyc = own1 ? i_s1_cyc : i_s0_cyc;
  assign own_stb = own1 ? i_s1_stb : i_s0_stb;
  assign own_we  = own1 ? i_s1_we  : i_s0_we;
  assign busy    = (state_q == ST_BUSY);
  assign term    = i_mack | i_merr;

  assign wd_clear = !busy || term;
  assign wd_en    = busy && own_cyc && own_stb && !term;

  sdc_wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (aclk),
    .rst     (areset),
    .clear   (wd_clear),
    .cnt_en  (wd_en),
    .expired (expired)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_s0_cyc || i_s1_cyc) begin
            state_q <= ST_BUSY;
            // Requester 0 wins unless requester 1 is alone or it is 1's turn.
            if (i_s0_cyc && (!i_s1_cyc || last_q)) begin
              grant_q <= 2'b01;
              last_q  <= 1'b0;
            end else begin
              grant_q <= 2'b10;
              last_q  <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          if (!own_cyc) begin
            state_q <= ST_IDLE;
            grant_q <= 2'b00;
          end else if (expired) begin
            state_q <= ST_ABORT;
          end
        end
        ST_ABORT: begin
          if (!own_cyc) begin
            state_q <= ST_IDLE;
            grant_q <= 2'b00;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

  assign o_mcyc  = busy && own_cyc && !expired;
  assign o_mstb  = busy && own_cyc && own_stb && !expired;
  assign o_mwe   = busy && own_we;
  assign o_maddr = own1 ? i_s1_addr : i_s0_addr;
  assign o_mdata = own1 ? i_s1_data : i_s0_data;
  assign o_msel  = own1 ? i_s1_sel  : i_s0_sel;

  assign o_s0_ack  = busy && grant_q[0] && i_mack;
  assign o_s1_ack  = busy && grant_q[1] && i_mack;
  assign o_s0_err  = busy && grant_q[0] && (i_merr || expired);
  assign o_s1_err  = busy && grant_q[1] && (i_merr || expired);
  assign o_s_data  = i_mdata;
  assign o_grant   = grant_q;
  assign o_timeout = expired;

endmodule

// File: tb/tb_sdc_wb_arbiter.sv
// Directed bench for sdc_wb_arbiter with a short watchdog (TIMEOUT=8).
module tb_sdc_wb_arbiter;

  localparam int AW = 30;
  localparam int DW = 32;

  logic            aclk, areset;
  logic            s0_cyc, s0_stb, s0_we, s1_cyc, s1_stb, s1_we;
  logic [AW-1:0]   s0_addr, s1_addr, maddr;
  logic [DW-1:0]   s0_data, s1_data, s_data, mdata_out, mdata_in;
  logic [DW/8-1:0] s0_sel, s1_sel, msel;
  logic            s0_ack, s0_err, s1_ack, s1_err;
  logic            mcyc, mstb, mwe, mack, merr, timeout;
  logic [1:0]      grant;

  int checks = 0;
  int failures = 0;

  sdc_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .aclk(aclk), .areset(areset),
    .i_s0_cyc(s0_cyc), .i_s0_stb(s0_stb), .i_s0_we(s0_we), .i_s0_addr(s0_addr),
    .i_s0_data(s0_data), .i_s0_sel(s0_sel), .o_s0_ack(s0_ack), .o_s0_err(s0_err),
    .i_s1_cyc(s1_cyc), .i_s1_stb(s1_stb), .i_s1_we(s1_we), .i_s1_addr(s1_addr),
    .i_s1_data(s1_data), .i_s1_sel(s1_sel), .o_s1_ack(s1_ack), .o_s1_err(s1_err),
    .o_s_data(s_data), .o_mcyc(mcyc), .o_mstb(mstb), .o_mwe(mwe), .o_maddr(maddr),
    .o_mdata(mdata_out), .o_msel(msel), .i_mack(mack), .i_merr(merr),
    .i_mdata(mdata_in), .o_grant(grant), .o_timeout(timeout)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge aclk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL tb_time_limit got=running exp=finished");
    $fatal(1, "time limit");
  end

  initial begin
    areset = 1'b1;
    {s0_cyc, s0_stb, s0_we, s1_cyc, s1_stb, s1_we, mack, merr} = '0;
    s0_addr = '0; s1_addr = '0; s0_data = 32'h0000_1111; s1_data = 32'h2222_3333;
    s0_sel = 4'hF; s1_sel = 4'h3; mdata_in = 32'h1234_5678;

    repeat (2) step();
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_mcyc", mcyc, 0);
    chk("rst_mstb", mstb, 0);
    chk("rst_acks", {s0_ack, s0_err, s1_ack, s1_err}, 4'h0);
    chk("rst_timeout", timeout, 0);
    chk("rst_sdata", s_data, 32'h1234_5678);

    // Single read from requester 0, ack on the fourth BUSY cycle.
    step(); areset = 1'b0;
    step(); s0_cyc = 1; s0_stb = 1; s0_addr = 30'h10; #1;
    chk("r0_idle_grant", grant, 2'b00);
    chk("r0_idle_mcyc", mcyc, 0);
    step(); #1;
    chk("r0_grant", grant, 2'b01);
    chk("r0_mcyc", mcyc, 1);
    chk("r0_maddr", maddr, 30'h10);
    chk("r0_mwe", mwe, 0);
    step(); step(); #1;
    chk("r0_noack", s0_ack, 0);
    step(); mack = 1; mdata_in = 32'hCAFE_F00D; #1;
    chk("r0_ack", s0_ack, 1);
    chk("r0_s1_ack", s1_ack, 0);
    chk("r0_sdata", s_data, 32'hCAFE_F00D);
    step(); mack = 0; s0_cyc = 0; s0_stb = 0; #1;
    chk("r0_ack_gone", s0_ack, 0);
    chk("r0_drop_mcyc", mcyc, 0);
    step(); #1;
    chk("r0_release", grant, 2'b00);

    // Contention straight after reset: requester 0 first, then requester 1.
    areset = 1; #1;
    chk("rst2_grant", grant, 2'b00);
    step(); areset = 0;
    s0_cyc = 1; s0_stb = 1; s0_addr = 30'h20;
    s1_cyc = 1; s1_stb = 1; s1_we = 1; s1_addr = 30'h30;
    step(); mack = 1; #1;
    chk("c_grant0", grant, 2'b01);
    chk("c_maddr0", maddr, 30'h20);
    chk("c_s0_ack", s0_ack, 1);
    chk("c_s1_wait_ack", s1_ack, 0);
    step(); mack = 0; merr = 1; #1;
    chk("c_hold_grant", grant, 2'b01);
    chk("c_s0_err", s0_err, 1);
    chk("c_s1_wait_err", s1_err, 0);
    step(); merr = 0; s0_cyc = 0; s0_stb = 0; #1;
    chk("c_drop_mcyc", mcyc, 0);
    step(); #1;
    chk("c_gap_grant", grant, 2'b00);
    chk("c_gap_mcyc", mcyc, 0);
    step(); mack = 1; #1;
    chk("c_grant1", grant, 2'b10);
    chk("c_maddr1", maddr, 30'h30);
    chk("c_mwe1", mwe, 1);
    chk("c_mdata1", mdata_out, 32'h2222_3333);
    chk("c_msel1", msel, 4'h3);
    chk("c_s1_ack", s1_ack, 1);
    chk("c_s0_noack", s0_ack, 0);
    step(); mack = 0; s1_cyc = 0; s1_stb = 0; s1_we = 0;
    step(); #1;
    chk("c_release", grant, 2'b00);

    // Stalled strobe: watchdog fires on BUSY cycle 8.
    s0_cyc = 1; s0_stb = 1;
    step();
    for (int i = 1; i <= 7; i++) begin
      #1;
      chk($sformatf("to_quiet_%0d", i), timeout, 0);
      step();
    end
    #1;
    chk("to_pulse", timeout, 1);
    chk("to_s0_err", s0_err, 1);
    chk("to_s1_err", s1_err, 0);
    chk("to_mcyc", mcyc, 0);
    chk("to_mstb", mstb, 0);
    step(); mack = 1; #1;
    chk("ab_timeout", timeout, 0);
    chk("ab_err", s0_err, 0);
    chk("ab_ack_discard", s0_ack, 0);
    chk("ab_grant", grant, 2'b01);
    chk("ab_mcyc", mcyc, 0);
    step(); mack = 0; #1;
    chk("ab_hold", grant, 2'b01);
    s0_cyc = 0; s0_stb = 0;
    step(); #1;
    chk("ab_exit", grant, 2'b00);

    // Ack lands on the watchdog limit cycle: termination wins.
    s0_cyc = 1; s0_stb = 1;
    step();
    for (int i = 1; i <= 7; i++) step();
    mack = 1; #1;
    chk("tie_ack", s0_ack, 1);
    chk("tie_timeout", timeout, 0);
    chk("tie_err", s0_err, 0);
    chk("tie_mcyc", mcyc, 1);
    step(); mack = 0; #1;
    chk("tie_after_to", timeout, 0);
    chk("tie_after_grant", grant, 2'b01);
    chk("tie_after_mcyc", mcyc, 1);
    s0_cyc = 0; s0_stb = 0;
    step(); #1;
    chk("tie_release", grant, 2'b00);

    // Requester 1 wins by round robin, then reset hits mid-burst.
    s0_cyc = 1; s0_stb = 1; s1_cyc = 1; s1_stb = 1; s1_we = 1;
    step(); mack = 1; #1;
    chk("rr_grant1", grant, 2'b10);
    chk("rr_s1_ack", s1_ack, 1);
    step(); areset = 1; #1;
    chk("mid_grant", grant, 2'b00);
    chk("mid_mcyc", mcyc, 0);
    chk("mid_mstb", mstb, 0);
    chk("mid_mwe", mwe, 0);
    chk("mid_acks", {s0_ack, s0_err, s1_ack, s1_err}, 4'h0);
    chk("mid_timeout", timeout, 0);
    step(); areset = 0; mack = 0;
    step(); #1;
    chk("mid_next_grant", grant, 2'b01);

    {s0_cyc, s0_stb, s1_cyc, s1_stb, s1_we} = '0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
